// File: rtl/rr_arb8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb8
//  Description : 8-way round-robin arbiter with a hold-time limit. Grants are
//                registered, separated by one idle cycle, and the granted
//                index is also presented as an active-low seven-segment code.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic [6:0] hex
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_GRANT    = 1'b1;
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [6:0] C_HEX_BLANK = 7'b1111111;

    logic [0:0] r_state, w_state_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hcnt, w_hcnt_nxt;
    logic [7:0] r_gnt, w_gnt_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic       r_valid, w_valid_nxt;
    logic [6:0] r_hex, w_hex_nxt;

    logic       w_found;
    logic [2:0] w_pick;
    logic [2:0] w_cand;
    logic       w_own_req;
    logic       w_others;
    logic       w_at_last;
    logic       w_timeout;
    logic       w_release;

    // Seven-segment (active-low, gfedcba) code for a 3-bit index
    function automatic logic [6:0] seg7(input logic [2:0] v);
        case (v)
            3'd0:    seg7 = 7'b1000000;
            3'd1:    seg7 = 7'b1111001;
            3'd2:    seg7 = 7'b0100100;
            3'd3:    seg7 = 7'b0110000;
            3'd4:    seg7 = 7'b0011001;
            3'd5:    seg7 = 7'b0010010;
            3'd6:    seg7 = 7'b0000010;
            default: seg7 = 7'b1111000;
        endcase
    endfunction

    // Rotating priority search: first requester at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_cand  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_cand = r_ptr + 3'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Release qualifiers for the current owner
    always_comb begin
        w_own_req = req[r_idx];
        w_others  = |(req & ~r_gnt);
        w_at_last = (r_hcnt == C_HOLD_LAST);
        w_timeout = w_at_last && w_others;
        w_release = !w_own_req || !en || w_timeout;
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hcnt_nxt  = r_hcnt;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_hex_nxt   = r_hex;
        case (r_state)
            S_IDLE: begin
                if (en && w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = 8'b1 << w_pick;
                    w_idx_nxt   = w_pick;
                    w_valid_nxt = 1'b1;
                    w_hcnt_nxt  = 8'd0;
                    w_hex_nxt   = seg7(w_pick);
                end
            end
            default: begin
                if (w_release) begin
                    // A pure enable drop keeps the owner first in line later
                    if (en || !w_own_req || w_timeout)
                        w_ptr_nxt = r_idx + 3'd1;
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 8'd0;
                    w_idx_nxt   = 3'd0;
                    w_valid_nxt = 1'b0;
                    w_hcnt_nxt  = 8'd0;
                    w_hex_nxt   = C_HEX_BLANK;
                end else if (w_at_last) begin
                    // Nobody else waiting: keep the grant, restart the window
                    w_hcnt_nxt = 8'd0;
                end else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_hcnt  <= 8'd0;
            r_gnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_hex   <= C_HEX_BLANK;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_hex   <= w_hex_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign hex       = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb8
//  Description : Scoreboard bench for rr_arb8. A cycle-level reference model
//                predicts the outputs after every edge; a monitor pops and
//                compares them half a cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb8;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [6:0] hex;

    rr_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .hex      (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic [6:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [6:0] hex_lut [8];
    initial begin
        hex_lut[0] = 7'b1000000; hex_lut[1] = 7'b1111001;
        hex_lut[2] = 7'b0100100; hex_lut[3] = 7'b0110000;
        hex_lut[4] = 7'b0011001; hex_lut[5] = 7'b0010010;
        hex_lut[6] = 7'b0000010; hex_lut[7] = 7'b1111000;
    end

    // Reference model: who owns the bus, for how many cycles, and where the
    // next search begins.
    bit m_busy;
    int m_owner;
    int m_held;
    int m_next;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_held  = 0;
        m_next  = 0;
    endtask

    task automatic model_edge(input logic e, input logic [7:0] r);
        bit others;
        bit expired;
        if (!m_busy) begin
            if (e && r != 8'd0) begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m_next + k) % 8]) begin
                        m_owner = (m_next + k) % 8;
                        break;
                    end
                end
                m_busy = 1;
                m_held = 1;
            end
        end else begin
            others  = (r & ~(8'd1 << m_owner)) != 8'd0;
            expired = (m_held == MAX_HOLD) && others;
            if (!r[m_owner] || !e || expired) begin
                if (e || !r[m_owner] || expired)
                    m_next = (m_owner + 1) % 8;
                m_busy = 0;
            end else begin
                m_held = (m_held == MAX_HOLD) ? 1 : m_held + 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.valid = m_busy;
        x.gnt   = m_busy ? (8'd1 << m_owner) : 8'd0;
        x.idx   = m_busy ? 3'(m_owner) : 3'd0;
        x.hex   = m_busy ? hex_lut[m_owner] : 7'b1111111;
        return x;
    endfunction

    task automatic check_now(input string tag, input exp_t x);
        n_cmp++;
        if (gnt !== x.gnt || gnt_idx !== x.idx || gnt_valid !== x.valid || hex !== x.hex) begin
            n_fail++;
            $display("FAIL %s t=%0t got gnt=%b idx=%0d v=%b hex=%b exp gnt=%b idx=%0d v=%b hex=%b",
                     tag, $time, gnt, gnt_idx, gnt_valid, hex, x.gnt, x.idx, x.valid, x.hex);
        end
    endtask

    // Monitor: one expectation per edge, checked at the falling edge
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check_now("edge", x);
            end
        end
    end

    // Apply inputs, let one edge pass, record the predicted response
    task automatic drive(input logic e, input logic [7:0] r);
        en  = e;
        req = r;
        @(posedge clk);
        model_edge(e, r);
        exp_q.push_back(model_out());
        #2;
    endtask

    // Reset pulse between edges; outputs must clear before the next edge
    task automatic async_reset();
        exp_t z;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        z = model_out();
        check_now("async_rst", z);
        rst = 1'b0;
        #1;
        check_now("post_rst", z);
    endtask

    initial begin
        exp_t z;
        rst = 1'b1;
        en  = 1'b0;
        req = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        z = model_out();
        check_now("reset", z);
        en  = 1'b1;
        req = 8'hFF;
        @(posedge clk);
        #2;
        check_now("reset_held", z);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        req = 8'd0;

        // priority after reset, then rotation with wrap
        drive(1'b1, 8'b1010_0100);
        drive(1'b1, 8'b1010_0100);
        drive(1'b1, 8'b1010_0000);
        drive(1'b1, 8'b1010_0000);
        drive(1'b1, 8'b1010_0000);
        drive(1'b1, 8'b1000_0000);
        drive(1'b1, 8'b1000_0000);
        drive(1'b1, 8'b1000_0001);
        drive(1'b1, 8'b0000_0001);
        drive(1'b1, 8'b0000_0001);
        drive(1'b1, 8'b0000_0000);

        // timeout between two steady requesters
        async_reset();
        repeat (14) drive(1'b1, 8'b0001_1000);
        drive(1'b1, 8'b0000_0000);

        // lone requester keeps the grant past the hold window
        repeat (20) drive(1'b1, 8'b0100_0000);
        drive(1'b1, 8'b0000_0000);

        // enable drop keeps the pointer on the dropped owner
        async_reset();
        drive(1'b1, 8'b0000_0010);
        drive(1'b1, 8'b0000_0010);
        drive(1'b0, 8'b0000_0010);
        drive(1'b0, 8'b1000_0010);
        drive(1'b1, 8'b1000_0010);
        drive(1'b1, 8'b1000_0010);

        // reset mid-grant, then first grant searches from zero
        async_reset();
        drive(1'b1, 8'b1010_0010);
        drive(1'b1, 8'b1010_0010);
        drive(1'b1, 8'b0000_0000);

        // randomized traffic
        begin
            logic       e;
            logic [7:0] r;
            e = 1'b1;
            r = 8'd0;
            for (int n = 0; n < 2000; n++) begin
                if ($urandom_range(0, 3) == 0) r = 8'($urandom);
                else if ($urandom_range(0, 7) == 0) r = 8'd1 << $urandom_range(0, 7);
                e = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 299) == 0) async_reset();
                drive(e, r);
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
